// File: rtl/irq_ctrl.sv
// irq_ctrl: two-source interrupt controller (keypad, ethernet).
// Rising edges on the source levels are captured into per-source pending
// bits and payload buffers, and a three-state FSM presents one request at a
// time to the processor. Lost events are recorded in sticky overflow flags.
module irq_ctrl #(
   parameter int ETH_HIGH = 1   // 1: eth outranks key, 0: key outranks eth
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_irq,
   input  logic [31:0] key_data,
   input  logic        eth_irq,
   input  logic [31:0] eth_data,
   input  logic        int_en,
   input  logic        int_ack,
   input  logic        int_done,
   input  logic        clr_ovf,
   output logic        irq,
   output logic [1:0]  irq_src,
   output logic [31:0] irq_data,
   output logic [1:0]  ovf
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_REQ     = 2'd1;
   localparam logic [1:0] S_SERVICE = 2'd2;

   localparam logic [1:0] SRC_NONE = 2'b00;
   localparam logic [1:0] SRC_KEY  = 2'b01;
   localparam logic [1:0] SRC_ETH  = 2'b10;

   logic [1:0]  state;
   logic        key_prev, eth_prev;
   logic [1:0]  pend;          // bit0 key, bit1 eth
   logic [31:0] key_buf, eth_buf;

   logic        key_ev, eth_ev;
   logic        ack_fire, key_clr, eth_clr;
   logic        key_lost, eth_lost;
   logic [1:0]  win_src;
   logic [31:0] win_data;

   assign key_ev   = key_irq & ~key_prev;
   assign eth_ev   = eth_irq & ~eth_prev;

   // The ack clears the served source; an event arriving on that same edge
   // re-arms it instead of counting as lost.
   assign ack_fire = (state == S_REQ) & int_ack;
   assign key_clr  = ack_fire & (irq_src == SRC_KEY);
   assign eth_clr  = ack_fire & (irq_src == SRC_ETH);
   assign key_lost = key_ev & pend[0] & ~key_clr;
   assign eth_lost = eth_ev & pend[1] & ~eth_clr;

   // Pick the highest-priority pending source and its payload.
   always_comb begin
      win_src  = SRC_NONE;
      win_data = 32'd0;
      if (ETH_HIGH != 0) begin
         if (pend[1]) begin
            win_src  = SRC_ETH;
            win_data = eth_buf;
         end else if (pend[0]) begin
            win_src  = SRC_KEY;
            win_data = key_buf;
         end
      end else begin
         if (pend[0]) begin
            win_src  = SRC_KEY;
            win_data = key_buf;
         end else if (pend[1]) begin
            win_src  = SRC_ETH;
            win_data = eth_buf;
         end
      end
   end

   // Edge history, pending bits and payload buffers. During reset the
   // history tracks the inputs so a level already high is not an event.
   always_ff @(posedge clk) begin
      key_prev <= key_irq;
      eth_prev <= eth_irq;
      if (!rst_n) begin
         pend    <= 2'b00;
         key_buf <= 32'd0;
         eth_buf <= 32'd0;
      end else begin
         if (key_ev && !key_lost) begin
            pend[0] <= 1'b1;
            key_buf <= key_data;
         end else if (key_clr) begin
            pend[0] <= 1'b0;
         end
         if (eth_ev && !eth_lost) begin
            pend[1] <= 1'b1;
            eth_buf <= eth_data;
         end else if (eth_clr) begin
            pend[1] <= 1'b0;
         end
      end
   end

   // Sticky overflow flags; a new loss beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf <= 2'b00;
      end else begin
         ovf <= (clr_ovf ? 2'b00 : ovf) | {eth_lost, key_lost};
      end
   end

   // Request/service handshake with the processor; no nesting.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         irq      <= 1'b0;
         irq_src  <= SRC_NONE;
         irq_data <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (int_en && (pend != 2'b00)) begin
                  state    <= S_REQ;
                  irq      <= 1'b1;
                  irq_src  <= win_src;
                  irq_data <= win_data;
               end
            end
            S_REQ: begin
               if (int_ack) begin
                  state <= S_SERVICE;
                  irq   <= 1'b0;
               end else if (!int_en) begin
                  state   <= S_IDLE;
                  irq     <= 1'b0;
                  irq_src <= SRC_NONE;
               end
            end
            S_SERVICE: begin
               if (int_done) begin
                  state   <= S_IDLE;
                  irq_src <= SRC_NONE;
               end
            end
            default: begin
               state   <= S_IDLE;
               irq     <= 1'b0;
               irq_src <= SRC_NONE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed stimulus with a scoreboard. Each expected request
// is queued when its triggering event is driven; a monitor pops and checks
// whenever irq rises. Inline checks cover latency, masking, ovf and reset.
module tb_irq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        key_irq, eth_irq;
   logic [31:0] key_data, eth_data;
   logic        int_en, int_ack, int_done, clr_ovf;
   logic        irq;
   logic [1:0]  irq_src;
   logic [31:0] irq_data;
   logic [1:0]  ovf;

   typedef struct packed {
      logic [1:0]  src;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t sb_e;
   int   n_chk  = 0;
   int   n_fail = 0;
   logic irq_q  = 1'b0;

   irq_ctrl #(.ETH_HIGH(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .key_irq(key_irq), .key_data(key_data),
      .eth_irq(eth_irq), .eth_data(eth_data),
      .int_en(int_en), .int_ack(int_ack), .int_done(int_done),
      .clr_ovf(clr_ovf),
      .irq(irq), .irq_src(irq_src), .irq_data(irq_data), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] src, input logic [31:0] data);
      exp_q.push_back('{src: src, data: data});
   endtask

   task automatic ack();
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
   endtask

   task automatic done();
      int_done = 1'b1;
      tick();
      int_done = 1'b0;
   endtask

   // Scoreboard monitor: every new request must match the next expectation.
   always @(negedge clk) begin
      if (irq === 1'b1 && !irq_q) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected: got src %b data %h, expected no request", irq_src, irq_data);
         end else begin
            sb_e = exp_q.pop_front();
            chk("sb_src", 32'(irq_src), 32'(sb_e.src));
            chk("sb_data", irq_data, sb_e.data);
         end
      end
      irq_q <= (irq === 1'b1);
   end

   initial begin
      rst_n = 1'b0; key_irq = 1'b1; eth_irq = 1'b0;
      key_data = 32'd0; eth_data = 32'd0;
      int_en = 1'b0; int_ack = 1'b0; int_done = 1'b0; clr_ovf = 1'b0;

      // Reset with key level held high across release: no event.
      repeat (3) tick();
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_src", 32'(irq_src), 32'd0);
      chk("rst_data", irq_data, 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1; int_en = 1'b1;
      repeat (4) begin
         tick();
         chk("held_key_no_irq", 32'(irq), 32'd0);
      end
      key_irq = 1'b0;
      tick();

      // Single key event: irq two edges after the event.
      key_irq = 1'b1; key_data = 32'hDEADBEEF; push(2'b01, 32'hDEADBEEF);
      tick();
      chk("key_lat_e", 32'(irq), 32'd0);
      tick();
      chk("key_lat_e1", 32'(irq), 32'd1);
      chk("key_src", 32'(irq_src), 32'd1);
      ack();
      chk("key_ack_irq", 32'(irq), 32'd0);
      done();
      chk("key_done_src", 32'(irq_src), 32'd0);
      chk("key_done_data", irq_data, 32'hDEADBEEF);
      key_irq = 1'b0;
      tick();

      // Simultaneous events: eth first, key raised at D+1.
      key_irq = 1'b1; key_data = 32'h11; eth_irq = 1'b1; eth_data = 32'h22;
      push(2'b10, 32'h22); push(2'b01, 32'h11);
      tick(); tick();
      chk("prio_first_src", 32'(irq_src), 32'd2);
      ack();
      done();
      chk("prio_gap_irq", 32'(irq), 32'd0);
      tick();
      chk("prio_d1_irq", 32'(irq), 32'd1);
      chk("prio_second_src", 32'(irq_src), 32'd1);
      ack(); done();
      key_irq = 1'b0; eth_irq = 1'b0;
      tick();

      // Overflow: second key event before ack is lost.
      key_irq = 1'b1; key_data = 32'hA; push(2'b01, 32'hA);
      tick();
      key_irq = 1'b0;
      tick();
      key_irq = 1'b1; key_data = 32'hB;
      tick();
      key_irq = 1'b0;
      chk("ovf_set", 32'(ovf), 32'd1);
      chk("ovf_data_kept", irq_data, 32'hA);
      ack(); done();
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      chk("ovf_clr", 32'(ovf), 32'd0);
      tick();
      chk("ovf_no_reserve", 32'(irq), 32'd0);

      // Masking: pending eth waits for int_en, survives int_en drop in REQ.
      int_en = 1'b0; eth_irq = 1'b1; eth_data = 32'h55; push(2'b10, 32'h55);
      repeat (10) begin
         tick();
         chk("mask_irq_low", 32'(irq), 32'd0);
      end
      int_en = 1'b1;
      tick();
      chk("mask_en_irq", 32'(irq), 32'd1);
      chk("mask_en_src", 32'(irq_src), 32'd2);
      int_en = 1'b0;
      tick();
      chk("mask_drop_irq", 32'(irq), 32'd0);
      chk("mask_drop_src", 32'(irq_src), 32'd0);
      push(2'b10, 32'h55);
      int_en = 1'b1;
      tick();
      chk("mask_retained_irq", 32'(irq), 32'd1);
      ack(); done();
      eth_irq = 1'b0;
      tick();

      // Event on the served source at the ack edge is re-served, no ovf.
      key_irq = 1'b1; key_data = 32'h1; push(2'b01, 32'h1);
      tick(); tick();
      key_irq = 1'b0;
      tick();
      key_irq = 1'b1; key_data = 32'h2; int_ack = 1'b1; push(2'b01, 32'h2);
      tick();
      int_ack = 1'b0; key_irq = 1'b0;
      chk("coll_ack_irq", 32'(irq), 32'd0);
      chk("coll_ovf", 32'(ovf), 32'd0);
      done();
      tick();
      chk("coll_reserve_irq", 32'(irq), 32'd1);
      chk("coll_reserve_data", irq_data, 32'h2);
      ack(); done();

      // Reset during SERVICE with an eth event in flight.
      key_irq = 1'b1; key_data = 32'h77; push(2'b01, 32'h77);
      tick(); tick();
      key_irq = 1'b0;
      ack();
      eth_irq = 1'b1; eth_data = 32'h99; rst_n = 1'b0;
      tick();
      chk("srst_irq", 32'(irq), 32'd0);
      chk("srst_src", 32'(irq_src), 32'd0);
      chk("srst_data", irq_data, 32'd0);
      chk("srst_ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;
      repeat (3) begin
         tick();
         chk("srst_no_irq", 32'(irq), 32'd0);
      end
      eth_irq = 1'b0;
      tick();

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL have parameter ETH_HIGH, default 1, meaning 1 = eth outranks key, 0 = key outranks eth.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-004 The block SHALL have port key_irq, input, 1, keypad interrupt level; a rising edge is an event.
REQ-005 The block SHALL have port key_data, input, 32, key payload, valid in the key_irq rising-edge cycle.
REQ-006 The block SHALL have port eth_irq, input, 1, ethernet interrupt level; a rising edge is an event.
REQ-007 The block SHALL have port eth_data, input, 32, eth payload, valid in the eth_irq rising-edge cycle.
REQ-008 The block SHALL have port int_en, input, 1, processor global interrupt enable.
REQ-009 The block SHALL have port int_ack, input, 1, one-cycle pulse: processor vectored to the handler.
REQ-010 The block SHALL have port int_done, input, 1, one-cycle pulse: processor returned from the handler.
REQ-011 The block SHALL have port clr_ovf, input, 1, clears the overflow flags.
REQ-012 The block SHALL have port irq, output, 1, interrupt request to the processor.
REQ-013 The block SHALL have port irq_src, output, 2, served source: 00 none, 01 key, 10 eth.
REQ-014 The block SHALL have port irq_data, output, 32, payload of the served source, i.e. the processor's interrupt_source_data.
REQ-015 The block SHALL have port ovf, output, 2, sticky lost-event flags: bit0 key, bit1 eth.

Function
REQ-016 Edge detection SHALL use a registered previous sample per source; event = input high and previous sample low.
REQ-017 A key or eth event SHALL set that source's pending bit and capture its payload into that source's buffer, effective at the same edge.
REQ-018 An event on a source whose pending bit is already set SHALL leave the buffer unchanged and set that source's ovf bit.
REQ-019 The FSM SHALL have exactly three states: IDLE, REQ and SERVICE.
REQ-020 IDLE -> REQ SHALL occur when int_en=1 and any pending bit is set; the winner is chosen per ETH_HIGH, and irq_src and irq_data are latched from it.
REQ-021 In REQ, irq SHALL be 1, and irq_src and irq_data SHALL stay stable regardless of new events.
REQ-022 REQ -> SERVICE SHALL occur on int_ack=1; this clears the winner's pending bit and drives irq to 0.
REQ-023 REQ -> IDLE SHALL occur if int_en=0 and int_ack=0; irq drops, pending bits are kept, and irq_src becomes 00.
REQ-024 SERVICE -> IDLE SHALL occur on int_done=1; irq_src becomes 00 and irq_data holds its last value. Nesting is not supported, so no new irq is raised in SERVICE.
REQ-025 int_ack outside REQ and int_done outside SERVICE SHALL be ignored.
REQ-026 If an event on the served source coincides with int_ack, set SHALL win: pending stays 1, the buffer takes the new payload, and ovf is not set.
REQ-027 Latency: an event sampled at edge E SHALL set pending at E, and irq SHALL be 1 after edge E+1 if the FSM is IDLE and int_en=1.
REQ-028 Back-to-back: after int_done at edge D, a remaining pending source SHALL raise irq after edge D+1.
REQ-029 clr_ovf=1 SHALL clear both ovf bits; an overflow in the same cycle SHALL win over clr_ovf.
REQ-030 irq, irq_src and ovf SHALL be driven directly from flops, with no combinational path from any input.

Reset
REQ-031 While rst_n=0 at a clk edge, the block SHALL set state IDLE, irq=0, irq_src=00, irq_data=0, ovf=00, pending=00 and both buffers=0.
REQ-032 During reset, the previous-sample registers SHALL load the current key_irq and eth_irq, so an input already high at reset release is not an event.
REQ-033 Reset asserted in REQ or SERVICE SHALL abort service; irq SHALL be 0 after the first reset edge and any in-flight event is discarded.

Verification
REQ-034 Single key event: int_en=1, key_irq rises with key_data=0xDEADBEEF -> irq=1 two edges later, irq_src=01, irq_data=0xDEADBEEF; int_ack -> irq=0 next edge; int_done -> IDLE.
REQ-035 Priority: key and eth rise in the same cycle (key_data=0x11, eth_data=0x22), ETH_HIGH=1 -> eth is served first (10, 0x22); after int_done, key is served (01, 0x11) with irq high after D+1.
REQ-036 Overflow: key event (0xA), then a second key event (0xB) before int_ack -> ovf=01 and the served data is 0xA; clr_ovf -> ovf=00.
REQ-037 Masking: int_en=0 with an eth event -> irq stays 0 for 10 cycles; int_en=1 -> irq=1 next edge with irq_src=10; dropping int_en in REQ -> irq=0 and pending is retained.
REQ-038 Reset: key_irq held high across rst_n deassertion -> no irq; assert rst_n=0 in SERVICE -> all outputs reset values after one edge.
REQ-039 Ack/event collision: a key event on the int_ack edge of a key service -> after int_done, key is re-served with the new payload and ovf=00.
